md_unit: RTL

Multiply/divide unit in the EX stage. Executes the multiply, divide and multiply-accumulate operations flagged by the instruction decoder's `start`/`MDOp` outputs over a fixed multi-cycle latency. Owns the architectural HI/LO registers and serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads. While an operation is in flight, `busy` tells the hazard unit to stall any following HI/LO-touching instruction (`mdop`) in ID.

---
 rtl/md_unit.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit -- EX-stage multiply/divide unit owning the architectural HI/LO pair.
//
// Launches mult/multu/div/divu (and, when built with MD_MADD_EN,
// madd/maddu/msub/msubu) with a fixed latency, and serves mthi/mtlo writes
// and mfhi/mflo reads.
//
// Configuration macro:
//   MD_MADD_EN  defined   -> multiply-accumulate/subtract ops are built.
//               undefined -> a start with MDOp[2]=1 is ignored entirely.
//
// Parameters:
//   MULT_CYCLES  busy length of multiply-class ops (>= 1)
//   DIV_CYCLES   busy length of divide ops (>= 1)
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   start    in   launch the operation selected by MDOp
//   MDOp     in   000 multu, 001 mult, 010 divu, 011 div,
//                 100 madd, 110 maddu, 101 msub, 111 msubu
//   mthi     in   HI <- A (idle only)
//   mtlo     in   LO <- A (idle only)
//   mfhi     in   md_out selects HI when 1, LO when 0
//   A, B     in   forwarded rs / rt operands
//   busy     out  operation in flight (counter non-zero)
//   hi, lo   out  HI / LO registers
//   md_out   out  combinational mfhi ? hi : lo
// ---------------------------------------------------------------------------
module md_unit #(
    parameter int unsigned MULT_CYCLES = 32'd5,
    parameter int unsigned DIV_CYCLES  = 32'd10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDOp,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
`ifdef MD_MADD_EN
    localparam int unsigned OP_W = 32'd3;
`else
    localparam int unsigned OP_W = 32'd2;
`endif

    // 64-bit product of two 32-bit operands, sign- or zero-extended first.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        return ax * bx;
    endfunction

    // Two's-complement negate when neg is set (magnitude/sign restore).
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MD_MADD_EN
    logic [63:0]      acc_q, acc_d;
`endif

    logic        busy_s;
    logic        start_ok_s;
    logic        start_div_s;
    logic        is_div_s;
    logic        mul_sgn_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic        div_zero_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;
    logic [63:0] prod_s;
    logic [63:0] res_s;

    assign busy_s      = (cnt_q != CNT_ZERO);
    assign start_div_s = (MDOp[2:1] == 2'b01);
`ifdef MD_MADD_EN
    assign start_ok_s  = start;
`else
    // Accumulate ops are not built: such a start is simply dropped.
    assign start_ok_s  = start & ~MDOp[2];
`endif

    assign busy   = busy_s;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = mfhi ? hi_q : lo_q;

    // Result datapath computed from the operands latched at start.
    always_comb begin
`ifdef MD_MADD_EN
        is_div_s  = (op_q[2:1] == 2'b01);
        mul_sgn_s = op_q[2] ? ~op_q[1] : op_q[0];
`else
        is_div_s  = op_q[1];
        mul_sgn_s = op_q[0];
`endif
        prod_s = mul64(a_q, b_q, mul_sgn_s);

        // Divide on magnitudes; quotient sign = sign(A)^sign(B), remainder
        // follows the dividend. 0x80000000/-1 wraps back to 0x80000000.
        a_neg_s    = op_q[0] & a_q[31];
        b_neg_s    = op_q[0] & b_q[31];
        a_mag_s    = cond_neg(a_q, a_neg_s);
        b_mag_s    = cond_neg(b_q, b_neg_s);
        div_zero_s = (b_q == 32'd0);
        b_safe_s   = div_zero_s ? 32'd1 : b_mag_s;
        q_mag_s    = a_mag_s / b_safe_s;
        r_mag_s    = a_mag_s % b_safe_s;

        if (is_div_s) begin
            res_s = {cond_neg(r_mag_s, a_neg_s), cond_neg(q_mag_s, a_neg_s ^ b_neg_s)};
        end else begin
`ifdef MD_MADD_EN
            if (op_q[2]) begin
                res_s = op_q[0] ? (acc_q - prod_s) : (acc_q + prod_s);
            end else begin
                res_s = prod_s;
            end
`else
            res_s = prod_s;
`endif
        end
    end

    // Next-state: count down while busy, launch or serve mthi/mtlo when idle.
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
`ifdef MD_MADD_EN
        acc_d = acc_q;
`endif
        if (busy_s) begin
            cnt_d = cnt_q - CNT_ONE;
            // Final cycle commits the result, except divide-by-zero.
            if ((cnt_q == CNT_ONE) && !(is_div_s && div_zero_s)) begin
                hi_d = res_s[63:32];
                lo_d = res_s[31:0];
            end else begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        end else if (start_ok_s) begin
            a_d   = A;
            b_d   = B;
            op_d  = MDOp[OP_W-1:0];
            cnt_d = start_div_s ? DIV_LOAD : MULT_LOAD;
`ifdef MD_MADD_EN
            acc_d = {hi_q, lo_q};
`endif
        end else begin
            hi_d = mthi ? A : hi_q;
            lo_d = mtlo ? A : lo_q;
        end
    end

    // State registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            op_q  <= {OP_W{1'b0}};
            cnt_q <= CNT_ZERO;
`ifdef MD_MADD_EN
            acc_q <= 64'd0;
`endif
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
`ifdef MD_MADD_EN
            acc_q <= acc_d;
`endif
        end
    end

endmodule
